// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: priority encoder with fixed or round-robin priority and a
// single-entry valid/ready output register.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : d and rr_mode are valid this cycle
//   in_ready  : an input can be accepted this cycle (!out_valid || out_ready)
//   d         : request vector, bit i = request i
//   rr_mode   : 0 = fixed priority (MSB wins), 1 = round-robin from ptr
//   out_valid : a result is held on y/zero/multi
//   out_ready : consumer takes the result this cycle
//   y         : winning request index
//   zero      : accepted d was all-zero
//   multi     : accepted d had two or more bits set
module prio_encoder_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  input  logic         rr_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         multi
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] y_q, y_d;
  logic         zero_q, zero_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [W-1:0] fix_idx;
  logic [N-1:0] rot;
  logic [W-1:0] rr_off;
  logic [W:0]   rr_sum;
  logic [W-1:0] rr_idx;
  logic [W-1:0] y_new;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Fixed priority: the highest set bit wins, so later (higher) hits overwrite.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (d[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: rotate d so that bit ptr lands at position 0, find the lowest
  // set bit of the rotated vector, then add ptr back modulo N.
  always_comb begin
    rot    = N'({d, d} >> ptr_q);
    rr_off = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = W'(i);
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    if (rr_sum >= (W+1)'(N)) begin
      rr_idx = W'(rr_sum - (W+1)'(N));
    end else begin
      rr_idx = rr_sum[W-1:0];
    end
  end

  always_comb begin
    if (d == '0) begin
      y_new = '0;
    end else if (rr_mode) begin
      y_new = rr_idx;
    end else begin
      y_new = fix_idx;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = y_new;
      zero_d      = (d == '0);
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_d     = |(d & (d - N'(1)));
      if (rr_mode && (d != '0)) begin
        ptr_d = (y_new == W'(N - 1)) ? '0 : y_new + W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign multi     = multi_q;

endmodule
